// File: rtl/ex_wb_stage.sv
// EX->WB pipeline register: registers ALU/memory results and selects the
// writeback value, holds the Z/N flags, drives bypass hits, counts retires.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall, flush        hold all state / squash the captured instruction
//   in_valid            EX stage holds a real instruction
//   ALU_result, Zero,   ALU output and its zero/negative flags
//   Neg
//   read_data           data memory read output (same cycle as ALU_result)
//   MemToReg            1 selects read_data, 0 selects ALU_result
//   RegWrite, flag_we   register-file write and flag update enables
//   rd                  destination register
//   rs1_addr, rs2_addr  decode-stage sources for the bypass compare
//   wb_valid, wb_RegWrite, wb_rd, wb_data   registered writeback bundle
//   Z_flag, N_flag      architectural condition flags
//   fwd_rs1, fwd_rs2    wb stage will write rs1_addr / rs2_addr
//   retire_count        committed-instruction counter
module ex_wb_stage #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      ALU_result,
    input  logic                  Zero,
    input  logic                  Neg,
    input  logic [WIDTH-1:0]      read_data,
    input  logic                  MemToReg,
    input  logic                  RegWrite,
    input  logic                  flag_we,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  wb_valid,
    output logic                  wb_RegWrite,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [WIDTH-1:0]      wb_data,
    output logic                  Z_flag,
    output logic                  N_flag,
    output logic                  fwd_rs1,
    output logic                  fwd_rs2,
    output logic [31:0]           retire_count
);

    logic [31:0]      cnt_q;
    logic [WIDTH-1:0] sel_data;

    assign sel_data = MemToReg ? read_data : ALU_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            Z_flag      <= 1'b0;
            N_flag      <= 1'b0;
            cnt_q       <= '0;
        end else if (flush) begin
            // Squash only the bundle; flags and counter keep history.
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else if (!stall) begin
            wb_valid    <= in_valid;
            wb_RegWrite <= in_valid & RegWrite;
            wb_rd       <= rd;
            wb_data     <= sel_data;
            if (in_valid && flag_we) begin
                Z_flag <= Zero;
                N_flag <= Neg;
            end
            if (in_valid) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign retire_count = cnt_q;

    // Driven from registered state; only the address compare sees inputs.
    assign fwd_rs1 = wb_valid & wb_RegWrite & (wb_rd == rs1_addr);
    assign fwd_rs2 = wb_valid & wb_RegWrite & (wb_rd == rs2_addr);

endmodule
